issue_queue_scheduler: RTL and testbench
========================================

# issue_queue_scheduler

Out-of-order issue queue scheduler. It holds up to DEPTH pending micro-ops, tracks source-operand readiness through tag wakeup broadcasts, and issues up to ISS_WIDTH ready entries per cycle to execution ports. Free-slot allocation and issue selection are lowest-index-first through one StaticPrioritySelector instance. The block sits between rename/dispatch and the functional units.

## Interface
- DEPTH, 8, number of entries (≥ ENQ_WIDTH, ≥ ISS_WIDTH)
- ENQ_WIDTH, 2, dispatch ports
- ISS_WIDTH, 2, issue ports
- WAKE_WIDTH, 2, wakeup broadcast ports
- TAG_WIDTH, 6, physical register tag width
- PAYLOAD_WIDTH, 32, opaque micro-op payload width
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- flush_i  in  1  discard all entries
- enq_vld_i  in  [ENQ_WIDTH]  dispatch request
- enq_rdy_o  out  [ENQ_WIDTH]  free slot available for this port
- enq_payload_i  in  [ENQ_WIDTH][PAYLOAD_WIDTH]  micro-op payload
- enq_src_tag_i  in  [ENQ_WIDTH][2][TAG_WIDTH]  source tags
- enq_src_rdy_i  in  [ENQ_WIDTH][2]  source already available
- wake_vld_i  in  [WAKE_WIDTH]  wakeup valid
- wake_tag_i  in  [WAKE_WIDTH][TAG_WIDTH]  produced tag
- iss_vld_o  out  [ISS_WIDTH]  entry offered on port
- iss_rdy_i  in  [ISS_WIDTH]  execution port accepts
- iss_payload_o  out  [ISS_WIDTH][PAYLOAD_WIDTH]  offered payload, 0 when !iss_vld_o
- occupancy_o  out  $clog2(DEPTH+1)  valid entry count

## Operation
- Per-entry state: vld, payload, src_tag[2], src_rdy[2]. An entry is ready when vld && src_rdy[0] && src_rdy[1].
- Allocation: the selector's enqueue masks come from registered vld. Port k takes the k-th lowest free index. enq_rdy_o[k] = (mask k nonzero). Ports are independent; a port with vld low still reserves its slot, so port k+1 never shifts down.
- Enqueue on vld&&rdy writes the slot at the edge. Stored src_rdy = enq_src_rdy_i OR (any wake_vld_i whose wake_tag_i equals that src tag, same cycle).
- Wakeup: every valid entry source whose tag matches any valid wake port sets src_rdy at the edge. src_rdy never clears while an entry is valid.
- Selection: the selector's select mask is the ready vector. Port j gets the j-th lowest ready index. iss_vld_o[j] = (result mask j nonzero). iss_payload_o is an AND-OR mux of the one-hot mask.
- Issue: vld&&rdy on port j clears that entry's vld at the edge. If a port is not ready, its entry stays and port j+1 still receives the next entry (no re-steering).
- Entries freed this cycle are not allocatable until the next cycle.
- flush_i: all vld cleared at the edge. Flush overrides enqueue in the same cycle. Outputs in the flush cycle still reflect current state.
- occupancy_o: registered popcount of vld after the update.

## Timing
- Reset values: all vld = 0, iss_vld_o = 0, iss_payload_o = 0, occupancy_o = 0, enq_rdy_o = all 1.
- Enqueue at edge T with both sources ready gives iss_vld_o at T+1 (1-cycle minimum latency).
- Wake in cycle T sets readiness at edge T; issue is possible in cycle T+1. No same-cycle wake-to-issue.
- Full (occupancy == DEPTH): all enq_rdy_o = 0. With DEPTH−1 valid, only enq_rdy_o[0] = 1.
- Simultaneous issue of entry i and enqueue: the enqueue cannot target i in that cycle.
- Asynchronous rst mid-operation: state clears immediately and outputs take reset values without waiting for a clock edge.

## Structure
- Shared package iq_pkg: entry struct typedef (vld, payload, src_tag, src_rdy) and a tag-compare function.
- One sub-module: StaticPrioritySelector (Depth=DEPTH, EnqWidth=ENQ_WIDTH, SelWidth=ISS_WIDTH), fed with entry_vld and the ready vector.
- Entry array, wakeup CAM, payload muxes and occupancy counter live in this module.

## Test plan
- Reset, then enqueue two ops with all sources ready -> slots 0,1 written; next cycle iss_vld_o = 2'b11 with payloads in order; after accept, occupancy_o = 0.
- Fill all 8 entries with src_rdy = 0 -> enq_rdy_o = 0 once occupancy_o = 8. Wake tag 5 matching entry 3 src0 only -> no issue. Wake the entry 3 src1 tag -> iss_vld_o[0] next cycle with entry 3 payload.
- Enqueue with src tag 9 not ready while wake_tag 9 is valid the same cycle -> entry issues the next cycle.
- Entries 1,4,6 ready, iss_rdy_i = 2'b10 -> port0 offers 1 and is held, port1 offers 4 and retires. Next cycle port0 = 1, port1 = 6.
- flush_i with enq_vld_i = 2'b11 in the same cycle -> occupancy_o = 0, iss_vld_o = 0 next cycle, enq_rdy_o = all 1.
- Assert rst asynchronously while 5 entries are valid -> outputs reach reset values before the next edge; first post-reset enqueue lands in slot 0.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared types for the issue queue: per-entry state record and tag compare helper.
package iq_pkg;

  localparam int unsigned TAG_W     = 6;
  localparam int unsigned PAYLOAD_W = 32;

  typedef struct packed {
    logic                       vld;
    logic [PAYLOAD_W-1:0]       payload;
    logic [1:0][TAG_W-1:0]      src_tag;
    logic [1:0]                 src_rdy;
  } iq_entry_t;

  function automatic logic tag_match(input logic [TAG_W-1:0] a,
                                     input logic [TAG_W-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/issue_queue_scheduler_selector.sv
// Lowest-index-first selector: k-th free slot per enqueue port, j-th requester per select port.
module StaticPrioritySelector #(
  parameter int unsigned Depth    = 8,
  parameter int unsigned EnqWidth = 2,
  parameter int unsigned SelWidth = 2
) (
  input  logic [Depth-1:0]                entry_vld,
  input  logic [Depth-1:0]                sel_req,
  output logic [EnqWidth-1:0][Depth-1:0]  enq_mask,
  output logic [SelWidth-1:0][Depth-1:0]  sel_mask
);

  localparam int unsigned CW = $clog2(Depth + 1);

  logic [CW-1:0] free_cnt;
  logic [CW-1:0] req_cnt;

  // Running counts give each port its rank among free / requesting entries.
  always_comb begin
    enq_mask = '0;
    sel_mask = '0;
    free_cnt = '0;
    req_cnt  = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (!entry_vld[i]) begin
        for (int unsigned k = 0; k < EnqWidth; k++) begin
          if (32'(free_cnt) == k) enq_mask[k][i] = 1'b1;
        end
        free_cnt = free_cnt + CW'(1);
      end
      if (sel_req[i]) begin
        for (int unsigned j = 0; j < SelWidth; j++) begin
          if (32'(req_cnt) == j) sel_mask[j][i] = 1'b1;
        end
        req_cnt = req_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/issue_queue_scheduler.sv
// Out-of-order issue queue: entry array, tag wakeup CAM, priority allocate/issue, occupancy.
module issue_queue_scheduler
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned ENQ_WIDTH     = 2,
  parameter int unsigned ISS_WIDTH     = 2,
  parameter int unsigned WAKE_WIDTH    = 2,
  parameter int unsigned TAG_WIDTH     = TAG_W,
  parameter int unsigned PAYLOAD_WIDTH = PAYLOAD_W
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush_i,
  input  logic [ENQ_WIDTH-1:0]                          enq_vld_i,
  output logic [ENQ_WIDTH-1:0]                          enq_rdy_o,
  input  logic [ENQ_WIDTH-1:0][PAYLOAD_WIDTH-1:0]       enq_payload_i,
  input  logic [ENQ_WIDTH-1:0][1:0][TAG_WIDTH-1:0]      enq_src_tag_i,
  input  logic [ENQ_WIDTH-1:0][1:0]                     enq_src_rdy_i,
  input  logic [WAKE_WIDTH-1:0]                         wake_vld_i,
  input  logic [WAKE_WIDTH-1:0][TAG_WIDTH-1:0]          wake_tag_i,
  output logic [ISS_WIDTH-1:0]                          iss_vld_o,
  input  logic [ISS_WIDTH-1:0]                          iss_rdy_i,
  output logic [ISS_WIDTH-1:0][PAYLOAD_WIDTH-1:0]       iss_payload_o,
  output logic [$clog2(DEPTH+1)-1:0]                    occupancy_o
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  iq_entry_t [DEPTH-1:0]               entries;
  iq_entry_t [DEPTH-1:0]               entries_nxt;
  logic [DEPTH-1:0]                    entry_vld;
  logic [DEPTH-1:0]                    entry_ready;
  logic [ENQ_WIDTH-1:0][DEPTH-1:0]     enq_mask;
  logic [ISS_WIDTH-1:0][DEPTH-1:0]     sel_mask;
  logic [DEPTH-1:0][1:0]               entry_wake_hit;
  logic [ENQ_WIDTH-1:0][1:0]           enq_wake_hit;
  logic [OCC_W-1:0]                    occ_nxt;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_vld[i]   = entries[i].vld;
      entry_ready[i] = entries[i].vld & entries[i].src_rdy[0] & entries[i].src_rdy[1];
    end
  end

  StaticPrioritySelector #(
    .Depth    (DEPTH),
    .EnqWidth (ENQ_WIDTH),
    .SelWidth (ISS_WIDTH)
  ) u_sel (
    .entry_vld (entry_vld),
    .sel_req   (entry_ready),
    .enq_mask  (enq_mask),
    .sel_mask  (sel_mask)
  );

  always_comb begin
    for (int unsigned k = 0; k < ENQ_WIDTH; k++) enq_rdy_o[k] = |enq_mask[k];
    for (int unsigned j = 0; j < ISS_WIDTH; j++) begin
      iss_vld_o[j]     = |sel_mask[j];
      iss_payload_o[j] = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        iss_payload_o[j] = iss_payload_o[j]
                         | ({PAYLOAD_WIDTH{sel_mask[j][i]}} & entries[i].payload);
      end
    end
  end

  // Wakeup CAM covers both stored sources and the sources arriving on dispatch this cycle.
  always_comb begin
    entry_wake_hit = '0;
    enq_wake_hit   = '0;
    for (int unsigned w = 0; w < WAKE_WIDTH; w++) begin
      for (int unsigned s = 0; s < 2; s++) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (wake_vld_i[w] && tag_match(entries[i].src_tag[s], wake_tag_i[w]))
            entry_wake_hit[i][s] = 1'b1;
        end
        for (int unsigned k = 0; k < ENQ_WIDTH; k++) begin
          if (wake_vld_i[w] && tag_match(enq_src_tag_i[k][s], wake_tag_i[w]))
            enq_wake_hit[k][s] = 1'b1;
        end
      end
    end
  end

  // Enqueue masks only ever point at slots free in the registered state, so an
  // entry issuing this cycle can never be overwritten by a same-cycle enqueue.
  always_comb begin
    entries_nxt = entries;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries[i].vld) entries_nxt[i].src_rdy = entries[i].src_rdy | entry_wake_hit[i];
    end
    for (int unsigned j = 0; j < ISS_WIDTH; j++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (sel_mask[j][i] && iss_rdy_i[j]) entries_nxt[i].vld = 1'b0;
      end
    end
    for (int unsigned k = 0; k < ENQ_WIDTH; k++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (enq_vld_i[k] && enq_mask[k][i]) begin
          entries_nxt[i].vld     = 1'b1;
          entries_nxt[i].payload = enq_payload_i[k];
          entries_nxt[i].src_tag = enq_src_tag_i[k];
          entries_nxt[i].src_rdy = enq_src_rdy_i[k] | enq_wake_hit[k];
        end
      end
    end
    if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_nxt[i].vld = 1'b0;
    end
    occ_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) occ_nxt = occ_nxt + OCC_W'(entries_nxt[i].vld);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries     <= '0;
      occupancy_o <= '0;
    end else begin
      entries     <= entries_nxt;
      occupancy_o <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_issue_queue_scheduler.sv
// Directed bench for issue_queue_scheduler with an issue-order scoreboard.
module tb_issue_queue_scheduler;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [1:0]            enq_vld;
  logic [1:0]            enq_rdy;
  logic [1:0][31:0]      enq_payload;
  logic [1:0][1:0][5:0]  enq_src_tag;
  logic [1:0][1:0]       enq_src_rdy;
  logic [1:0]            wake_vld;
  logic [1:0][5:0]       wake_tag;
  logic [1:0]            iss_vld;
  logic [1:0]            iss_rdy;
  logic [1:0][31:0]      iss_payload;
  logic [3:0]            occupancy;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int          port;
    logic [31:0] payload;
  } exp_t;
  exp_t sb[$];

  issue_queue_scheduler #(
    .DEPTH(8), .ENQ_WIDTH(2), .ISS_WIDTH(2), .WAKE_WIDTH(2),
    .TAG_WIDTH(6), .PAYLOAD_WIDTH(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .enq_vld_i     (enq_vld),
    .enq_rdy_o     (enq_rdy),
    .enq_payload_i (enq_payload),
    .enq_src_tag_i (enq_src_tag),
    .enq_src_rdy_i (enq_src_rdy),
    .wake_vld_i    (wake_vld),
    .wake_tag_i    (wake_tag),
    .iss_vld_o     (iss_vld),
    .iss_rdy_i     (iss_rdy),
    .iss_payload_o (iss_payload),
    .occupancy_o   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    flush       = 1'b0;
    enq_vld     = '0;
    enq_payload = '0;
    enq_src_tag = '0;
    enq_src_rdy = '0;
    wake_vld    = '0;
    wake_tag    = '0;
    iss_rdy     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input int k, input logic [31:0] p, input logic [5:0] t0,
                         input logic [5:0] t1, input logic r0, input logic r1);
    enq_vld[k]        = 1'b1;
    enq_payload[k]    = p;
    enq_src_tag[k][0] = t0;
    enq_src_tag[k][1] = t1;
    enq_src_rdy[k][0] = r0;
    enq_src_rdy[k][1] = r1;
  endtask

  task automatic expect_iss(input int port, input logic [31:0] p);
    exp_t e;
    e.port    = port;
    e.payload = p;
    sb.push_back(e);
  endtask

  task automatic sample_issue();
    exp_t e;
    for (int j = 0; j < 2; j++) begin
      if (iss_vld[j]) begin
        if (sb.size() == 0) begin
          chk("iss_unexpected", iss_payload[j], '0);
        end else begin
          e = sb.pop_front();
          chk("iss_port", j, e.port);
          chk("iss_payload", iss_payload[j], e.payload);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12;
    chk("rst_iss_vld", iss_vld, 2'b00);
    chk("rst_payload0", iss_payload[0], 32'h0);
    chk("rst_payload1", iss_payload[1], 32'h0);
    chk("rst_occ", occupancy, 4'd0);
    chk("rst_enq_rdy", enq_rdy, 2'b11);
    rst = 1'b0;
    tick();

    // two ready ops issue one cycle after enqueue
    set_enq(0, 32'hA0, 6'd0, 6'd0, 1'b1, 1'b1);
    set_enq(1, 32'hA1, 6'd0, 6'd0, 1'b1, 1'b1);
    tick(); idle();
    chk("occ_two", occupancy, 4'd2);
    chk("iss_vld_two", iss_vld, 2'b11);
    expect_iss(0, 32'hA0); expect_iss(1, 32'hA1);
    sample_issue();
    iss_rdy = 2'b11;
    tick(); idle();
    chk("occ_drained", occupancy, 4'd0);
    chk("iss_vld_drained", iss_vld, 2'b00);

    // fill all slots with unready sources
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++)
        set_enq(k, 32'h100 + 32'(2*c+k), 6'(2*c+k+2), 6'(20+2*c+k), 1'b0, 1'b0);
      tick(); idle();
    end
    chk("occ_full", occupancy, 4'd8);
    chk("enq_rdy_full", enq_rdy, 2'b00);
    chk("iss_vld_full_unready", iss_vld, 2'b00);
    wake_vld = 2'b01; wake_tag[0] = 6'd5;
    tick(); idle();
    chk("partial_wake_no_issue", iss_vld, 2'b00);
    wake_vld = 2'b10; wake_tag[1] = 6'd23;
    tick(); idle();
    chk("iss_after_wake", iss_vld, 2'b01);
    expect_iss(0, 32'h103);
    sample_issue();
    iss_rdy = 2'b11;
    tick(); idle();
    chk("occ_depth_m1", occupancy, 4'd7);
    chk("enq_rdy_depth_m1", enq_rdy, 2'b01);
    chk("iss_vld_rest_unready", iss_vld, 2'b00);

    // flush wins over same-cycle enqueue
    flush = 1'b1;
    set_enq(0, 32'h1F0, 6'd0, 6'd0, 1'b1, 1'b1);
    set_enq(1, 32'h1F1, 6'd0, 6'd0, 1'b1, 1'b1);
    chk("flush_cycle_occ", occupancy, 4'd7);
    tick(); idle();
    chk("flush_occ", occupancy, 4'd0);
    chk("flush_iss_vld", iss_vld, 2'b00);
    chk("flush_enq_rdy", enq_rdy, 2'b11);

    // wake captured on the enqueue cycle
    set_enq(0, 32'h200, 6'd9, 6'd0, 1'b0, 1'b1);
    wake_vld = 2'b10; wake_tag[1] = 6'd9;
    tick(); idle();
    chk("enq_wake_iss_vld", iss_vld, 2'b01);
    expect_iss(0, 32'h200);
    sample_issue();

    // issuing slot 0 while enqueuing: new op must land in slot 1
    iss_rdy = 2'b01;
    set_enq(0, 32'h201, 6'd0, 6'd0, 1'b1, 1'b1);
    tick(); idle();
    chk("occ_after_swap", occupancy, 4'd1);
    expect_iss(0, 32'h201);
    sample_issue();
    set_enq(0, 32'h202, 6'd0, 6'd0, 1'b1, 1'b1);
    set_enq(1, 32'h203, 6'd0, 6'd0, 1'b1, 1'b1);
    tick(); idle();
    chk("occ_three", occupancy, 4'd3);
    chk("iss_vld_three", iss_vld, 2'b11);
    expect_iss(0, 32'h202); expect_iss(1, 32'h201);
    sample_issue();
    iss_rdy = 2'b11;
    tick(); idle();
    expect_iss(0, 32'h203);
    sample_issue();
    iss_rdy = 2'b01;
    tick(); idle();
    chk("occ_empty_again", occupancy, 4'd0);

    // entries 1,4,6 ready among 7 valid
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (2*c+k < 7) begin
          logic r;
          r = (2*c+k == 1) || (2*c+k == 4) || (2*c+k == 6);
          set_enq(k, 32'h300 + 32'(2*c+k), 6'(50+2*c+k), 6'(50+2*c+k), r, r);
        end
      end
      tick(); idle();
    end
    chk("occ_seven", occupancy, 4'd7);
    chk("enq_rdy_seven", enq_rdy, 2'b01);
    chk("iss_vld_146", iss_vld, 2'b11);
    expect_iss(0, 32'h301); expect_iss(1, 32'h304);
    sample_issue();
    iss_rdy = 2'b10;
    tick(); idle();
    chk("occ_six", occupancy, 4'd6);
    chk("iss_vld_held", iss_vld, 2'b11);
    expect_iss(0, 32'h301); expect_iss(1, 32'h306);
    sample_issue();
    iss_rdy = 2'b01;
    tick(); idle();
    chk("occ_five", occupancy, 4'd5);
    chk("iss_vld_last", iss_vld, 2'b01);
    expect_iss(0, 32'h306);
    sample_issue();

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_iss_vld", iss_vld, 2'b00);
    chk("arst_payload0", iss_payload[0], 32'h0);
    chk("arst_occ", occupancy, 4'd0);
    chk("arst_enq_rdy", enq_rdy, 2'b11);
    #2;
    rst = 1'b0;
    tick();
    set_enq(0, 32'h400, 6'd0, 6'd0, 1'b1, 1'b1);
    set_enq(1, 32'h401, 6'd0, 6'd0, 1'b1, 1'b1);
    tick(); idle();
    chk("post_rst_occ", occupancy, 4'd2);
    chk("post_rst_iss_vld", iss_vld, 2'b11);
    expect_iss(0, 32'h400); expect_iss(1, 32'h401);
    sample_issue();
    iss_rdy = 2'b11;
    tick(); idle();
    chk("post_rst_drained", occupancy, 4'd0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
